param_register_file: RTL and testbench

PARAM_REGISTER_FILE -- requirements
Module: param_register_file

---
 rtl/param_register_file_pkg.sv | 7 +
 rtl/param_register_file_if.sv | 29 ++
 rtl/param_register_file_read_pipe.sv | 27 ++
 rtl/param_register_file.sv | 58 +++++
 tb/tb_param_register_file.sv | 117 +++++++++++
 5 files changed

// File: rtl/param_register_file_pkg.sv
// param_reg_pkg: shared widths, latencies and parameter defaults for the register file
package param_reg_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int READ_LATENCY = 2;
  localparam int NUM_REGS_DEF = 16;
  localparam int ADDR_WIDTH_DEF = 8;
endpackage

// File: rtl/param_register_file_if.sv
// param_register_file_if: user command/read-return bus plus host write, readback and run-control signals
interface param_register_file_if #(parameter int ADDR_WIDTH = param_reg_pkg::ADDR_WIDTH_DEF);
  import param_reg_pkg::*;
  logic register32CmdReq;
  logic register32CmdAck;
  logic [ADDR_WIDTH-1:0] register32Address;
  logic register32WriteEn;
  logic [DATA_WIDTH-1:0] register32WriteData;
  logic register32ReadDataValid;
  logic [DATA_WIDTH-1:0] register32ReadData;
  logic userRunValue;
  logic userRunClear;
  logic hostWriteEn;
  logic [ADDR_WIDTH-1:0] hostAddress;
  logic [DATA_WIDTH-1:0] hostWriteData;
  logic hostRunSet;
  logic [ADDR_WIDTH-1:0] hostReadAddress;
  logic [DATA_WIDTH-1:0] hostReadData;
  modport master (
    output register32CmdReq, register32Address, register32WriteEn, register32WriteData,
           userRunClear, hostWriteEn, hostAddress, hostWriteData, hostRunSet, hostReadAddress,
    input  register32CmdAck, register32ReadDataValid, register32ReadData, userRunValue, hostReadData
  );
  modport slave (
    input  register32CmdReq, register32Address, register32WriteEn, register32WriteData,
           userRunClear, hostWriteEn, hostAddress, hostWriteData, hostRunSet, hostReadAddress,
    output register32CmdAck, register32ReadDataValid, register32ReadData, userRunValue, hostReadData
  );
endinterface

// File: rtl/param_register_file_read_pipe.sv
// reg32_read_pipe: two-stage valid/data read-return pipeline; data holds while no valid moves through
module reg32_read_pipe
  import param_reg_pkg::*;
(
  input  logic clk,
  input  logic resetN,
  input  logic in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);
  logic s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;
  always_ff @(posedge clk) begin
    if (!resetN) begin
      s1_valid <= 1'b0;
      s1_data <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
    end else begin
      s1_valid <= in_valid;
      out_valid <= s1_valid;
      s1_data <= in_valid ? in_data : s1_data;
      out_data <= s1_valid ? s1_data : out_data;
    end
  end
endmodule

// File: rtl/param_register_file.sv
// param_register_file: NUM_REGS x 32 flop register file with a user command port, host write/readback port and run flag
module param_register_file
  import param_reg_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input logic clk,
  input logic resetN,
  param_register_file_if.slave bus
);
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [ADDR_WIDTH-1:0] user_addr;
  logic accept;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] host_word;
  assign user_addr = bus.register32Address;
  assign bus.register32CmdAck = resetN & ~bus.hostWriteEn;
  assign accept = bus.register32CmdReq & bus.register32CmdAck;
  // out-of-range addresses match no entry, so reads fall through to zero
  always_comb begin
    rd_word = '0;
    host_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      rd_word = (32'(user_addr) == i) ? regs[i] : rd_word;
      host_word = (32'(bus.hostReadAddress) == i) ? regs[i] : host_word;
    end
  end
  always_ff @(posedge clk) begin
    if (!resetN) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (bus.hostWriteEn && 32'(bus.hostAddress) == i)
          regs[i] <= bus.hostWriteData;
        else if (accept && bus.register32WriteEn && 32'(user_addr) == i)
          regs[i] <= bus.register32WriteData;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!resetN) begin
      bus.hostReadData <= '0;
      bus.userRunValue <= 1'b0;
    end else begin
      bus.hostReadData <= host_word;
      bus.userRunValue <= bus.hostRunSet ? 1'b1 : bus.userRunClear ? 1'b0 : bus.userRunValue;
    end
  end
  reg32_read_pipe u_pipe (
    .clk(clk),
    .resetN(resetN),
    .in_valid(accept & ~bus.register32WriteEn),
    .in_data(rd_word),
    .out_valid(bus.register32ReadDataValid),
    .out_data(bus.register32ReadData)
  );
endmodule

// File: tb/tb_param_register_file.sv
// tb_param_register_file: directed stimulus with a read-return scoreboard drained by an independent monitor
module tb_param_register_file;
  logic clk = 1'b0;
  logic resetN = 1'b0;
  int passed = 0;
  int total = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model [16];
  param_register_file_if #(.ADDR_WIDTH(8)) bus();
  param_register_file #(.NUM_REGS(16), .ADDR_WIDTH(8)) dut (.clk(clk), .resetN(resetN), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic user_read(input logic [7:0] a, input logic [31:0] e);
    bus.register32CmdReq = 1'b1;
    bus.register32WriteEn = 1'b0;
    bus.register32Address = a;
    exp_q.push_back(e);
    tick();
  endtask
  // monitor: every valid strobe must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (bus.register32ReadDataValid) begin
      if (exp_q.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
      else check("read_data", bus.register32ReadData, exp_q.pop_front());
    end
  end
  initial begin
    bus.register32CmdReq = 0; bus.register32Address = 0; bus.register32WriteEn = 0;
    bus.register32WriteData = 0; bus.userRunClear = 0; bus.hostWriteEn = 0;
    bus.hostAddress = 0; bus.hostWriteData = 0; bus.hostRunSet = 0; bus.hostReadAddress = 0;
    for (int i = 0; i < 16; i++) model[i] = 0;
    tick(); tick();
    check("reset_ack", 32'(bus.register32CmdAck), 0);
    check("reset_run", 32'(bus.userRunValue), 0);
    check("reset_valid", 32'(bus.register32ReadDataValid), 0);
    check("reset_rdata", bus.register32ReadData, 0);
    check("reset_hrdata", bus.hostReadData, 0);
    resetN = 1;
    bus.hostWriteEn = 1; bus.hostAddress = 0; bus.hostWriteData = 32'hA5A5_0001; model[0] = 32'hA5A5_0001;
    tick();
    bus.hostAddress = 1; bus.hostWriteData = 32'h0000_0010; model[1] = 32'h0000_0010;
    tick();
    bus.hostWriteEn = 0;
    check("host_readback0", bus.hostReadData, 32'hA5A5_0001);
    bus.hostReadAddress = 1;
    user_read(0, 32'hA5A5_0001);
    check("host_readback1", bus.hostReadData, 32'h0000_0010);
    user_read(1, 32'h0000_0010);
    bus.register32CmdReq = 0;
    check("b2b_valid0", 32'(bus.register32ReadDataValid), 1);
    tick();
    check("b2b_valid1", 32'(bus.register32ReadDataValid), 1);
    tick();
    check("b2b_valid_end", 32'(bus.register32ReadDataValid), 0);
    bus.register32CmdReq = 1; bus.register32WriteEn = 0; bus.register32Address = 2;
    bus.hostWriteEn = 1; bus.hostAddress = 5; bus.hostWriteData = 32'h55; model[5] = 32'h55;
    for (int i = 0; i < 3; i++) begin
      #1 check("ack_blocked", 32'(bus.register32CmdAck), 0);
      tick();
    end
    bus.hostWriteEn = 0;
    #1 check("ack_released", 32'(bus.register32CmdAck), 1);
    exp_q.push_back(model[2]);
    tick();
    bus.register32WriteEn = 1; bus.register32Address = 3; bus.register32WriteData = 32'hDEAD_BEEF;
    model[3] = 32'hDEAD_BEEF;
    tick();
    user_read(3, 32'hDEAD_BEEF);
    user_read(8'h20, 0);
    bus.register32WriteEn = 1; bus.register32Address = 8'h20; bus.register32WriteData = 32'hFFFF_FFFF;
    tick();
    bus.register32Address = 8'h10;
    tick();
    for (int i = 0; i < 16; i++) user_read(8'(i), model[i]);
    user_read(8'h10, 0);
    bus.register32CmdReq = 0;
    tick(); tick(); tick();
    check("run_idle", 32'(bus.userRunValue), 0);
    bus.hostRunSet = 1;
    tick();
    bus.hostRunSet = 0;
    check("run_set", 32'(bus.userRunValue), 1);
    bus.hostRunSet = 1; bus.userRunClear = 1;
    tick();
    bus.hostRunSet = 0; bus.userRunClear = 0;
    check("run_set_wins", 32'(bus.userRunValue), 1);
    bus.userRunClear = 1;
    tick();
    bus.userRunClear = 0;
    check("run_clear", 32'(bus.userRunValue), 0);
    bus.register32CmdReq = 1; bus.register32WriteEn = 0; bus.register32Address = 3;
    tick();
    bus.register32CmdReq = 0; resetN = 0;
    #1 check("ack_in_reset", 32'(bus.register32CmdAck), 0);
    tick();
    resetN = 1;
    check("flush_valid", 32'(bus.register32ReadDataValid), 0);
    bus.hostReadAddress = 3;
    tick();
    check("flush_valid_late", 32'(bus.register32ReadDataValid), 0);
    check("post_reset_hrdata", bus.hostReadData, 0);
    for (int i = 0; i < 16; i++) user_read(8'(i), 0);
    bus.register32CmdReq = 0;
    tick(); tick(); tick(); tick();
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
